conv_engine_2d: RTL and testbench

CONV_ENGINE_2D -- requirements
Module: conv_engine_2d

---
 rtl/conv_pkg.sv | 24 ++
 rtl/line_buffer.sv | 29 ++
 rtl/conv_engine_2d.sv | 140 ++++++++++++++
 tb/tb_conv_engine_2d.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 Sobel-X convolution engine.
package conv_pkg;

  localparam int unsigned IMG_W_DEF = 32;
  localparam int unsigned IMG_H_DEF = 32;
  localparam int unsigned KSIZE     = 3;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned ACC_W     = 12;
  localparam int unsigned OUT_W     = 22;

  // Sobel-X: positive weights on the window's left column.
  localparam logic signed [3:0] KERNEL [KSIZE][KSIZE] = '{
    '{ 4'sd1, 4'sd0, -4'sd1},
    '{ 4'sd2, 4'sd0, -4'sd2},
    '{ 4'sd1, 4'sd0, -4'sd1}
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: dout is the sample written DEPTH enables ago.
module line_buffer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      mem[ptr] <= din;
      ptr      <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/conv_engine_2d.sv
// Streaming valid-only 3x3 Sobel-X convolution over a raster-order frame.
module conv_engine_2d
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_signal,
  input  logic                    pixel_valid,
  input  logic [PIX_W-1:0]        pixel_in,
  output logic signed [OUT_W-1:0] result_out,
  output logic                    result_valid,
  output logic                    done_signal
);

  localparam int unsigned COL_W = $clog2(IMG_W + 1);
  localparam int unsigned ROW_W = $clog2(IMG_H + 1);

  state_t                   state;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic                     accept;
  logic [PIX_W-1:0]         tap1;
  logic [PIX_W-1:0]         tap2;
  logic [PIX_W-1:0]         win [KSIZE][KSIZE];
  logic                     win_valid;
  logic                     win_last;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  sum_q;
  logic                     sum_valid;
  logic                     sum_last;
  logic                     res_last;

  // Pixels past the last row are dropped by the row-limit term.
  assign accept = (state == RUN) && pixel_valid && (row < ROW_W'(IMG_H));

  line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb0 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (pixel_in),
    .dout (tap1)
  );

  line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (tap1),
    .dout (tap2)
  );

  // Window row 0 is the oldest line; column 0 is the oldest column.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < KSIZE; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= tap2;
      win[1][2] <= tap1;
      win[2][2] <= pixel_in;
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) begin
        sum_c = sum_c + signed'(ACC_W'(win[i][j])) * ACC_W'(KERNEL[i][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      win_valid    <= 1'b0;
      win_last     <= 1'b0;
      sum_q        <= '0;
      sum_valid    <= 1'b0;
      sum_last     <= 1'b0;
      result_out   <= '0;
      result_valid <= 1'b0;
      res_last     <= 1'b0;
      done_signal  <= 1'b0;
    end else begin
      // Window complete only once two full rows and two columns precede it.
      win_valid <= accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
      win_last  <= accept && (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));

      sum_valid <= win_valid;
      sum_last  <= win_last;
      if (win_valid) sum_q <= sum_c;

      result_valid <= sum_valid;
      res_last     <= sum_last;
      if (sum_valid) result_out <= OUT_W'(sum_q);

      if (accept) begin
        if (col == COL_W'(IMG_W - 1)) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start_signal) begin
            state <= RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        RUN: begin
          if (result_valid && res_last) begin
            state       <= DONE;
            done_signal <= 1'b1;
          end
        end
        DONE: begin
          if (start_signal) begin
            state       <= RUN;
            done_signal <= 1'b0;
            col         <= '0;
            row         <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_engine_2d.sv
// Scoreboard bench for conv_engine_2d: expected values queued as pixels are driven.
module tb_conv_engine_2d;

  localparam int W = 32;
  localparam int H = 32;
  localparam int NRES = (W - 2) * (H - 2);

  logic               clk;
  logic               rst;
  logic               start_signal;
  logic               pixel_valid;
  logic [7:0]         pixel_in;
  logic signed [21:0] result_out;
  logic               result_valid;
  logic               done_signal;

  int n_vec;
  int n_err;
  int edge_cnt;
  int exp_q[$];
  int edge_q[$];

  conv_engine_2d #(.IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_signal (start_signal),
    .pixel_valid  (pixel_valid),
    .pixel_in     (pixel_in),
    .result_out   (result_out),
    .result_valid (result_valid),
    .done_signal  (done_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Patterns: 0 vertical edge, 1 checkerboard, 2 ramp 4*x, 3 uniform 200.
  function automatic logic [7:0] pix(input int pat, input int x, input int y);
    case (pat)
      0:       return (x < 16) ? 8'd0 : 8'd255;
      1:       return (((x + y) % 2) == 0) ? 8'd255 : 8'd0;
      2:       return 8'(4 * x);
      default: return 8'd200;
    endcase
  endfunction

  // Closed-form expected output for the default 32x32 frame.
  function automatic int exp_val(input int pat, input int c);
    case (pat)
      0:       return (c == 14 || c == 15) ? -1020 : 0;
      2:       return -32;
      default: return 0;
    endcase
  endfunction

  task automatic run_frame(input int pat, input int max_gap, input bit poke_start);
    int got;
    int cyc;
    int e;
    int t;
    @(negedge clk);
    start_signal = 1'b1;
    @(negedge clk);
    start_signal = 1'b0;
    n_vec++;
    if (done_signal !== 1'b0) begin
      n_err++;
      $display("FAIL start_clears_done: got %0b expected 0", done_signal);
    end
    exp_q.delete();
    edge_q.delete();
    fork
      begin
        for (int y = 0; y < H; y++) begin
          for (int x = 0; x < W; x++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (g > 0) begin
              pixel_valid  = 1'b0;
              start_signal = 1'b0;
              repeat (g) @(negedge clk);
            end
            pixel_valid  = 1'b1;
            pixel_in     = pix(pat, x, y);
            start_signal = poke_start && (y * W + x == 300);
            if (x >= 2 && y >= 2) begin
              exp_q.push_back(exp_val(pat, x - 2));
              edge_q.push_back(edge_cnt + 3);
            end
            @(negedge clk);
          end
        end
        start_signal = 1'b0;
        repeat (4) begin
          pixel_valid = 1'b1;
          pixel_in    = 8'($urandom);
          @(negedge clk);
        end
        pixel_valid = 1'b0;
      end
      begin
        got = 0;
        cyc = 0;
        while (got < NRES && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (result_valid === 1'b1) begin
            got++;
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_result: got %0d expected none", result_out);
            end else begin
              e = exp_q.pop_front();
              t = edge_q.pop_front();
              if (result_out !== 22'(e)) begin
                n_err++;
                $display("FAIL result_value #%0d: got %0d expected %0d", got, result_out, e);
              end
              n_vec++;
              if (edge_cnt != t) begin
                n_err++;
                $display("FAIL result_latency #%0d: got edge %0d expected edge %0d", got, edge_cnt, t);
              end
            end
            n_vec++;
            if (done_signal !== 1'b0) begin
              n_err++;
              $display("FAIL done_early #%0d: got %0b expected 0", got, done_signal);
            end
          end
        end
        n_vec++;
        if (got < NRES) begin
          n_err++;
          $display("FAIL result_count: got %0d expected %0d", got, NRES);
        end else begin
          @(negedge clk);
          n_vec++;
          if (done_signal !== 1'b1 || result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL done_after_last: got done=%0b valid=%0b expected done=1 valid=0",
                     done_signal, result_valid);
          end
        end
      end
    join
    repeat (8) begin
      pixel_valid = 1'b1;
      pixel_in    = 8'($urandom);
      @(negedge clk);
      n_vec++;
      if (result_valid !== 1'b0 || done_signal !== 1'b1) begin
        n_err++;
        $display("FAIL done_hold: got done=%0b valid=%0b expected done=1 valid=0",
                 done_signal, result_valid);
      end
    end
    pixel_valid = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %0b expected 0", result_valid);
    end
    n_vec++;
    if (done_signal !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: got %0b expected 0", done_signal);
    end
    n_vec++;
    if (result_out !== 22'sd0) begin
      n_err++;
      $display("FAIL reset_result: got %0d expected 0", result_out);
    end
    rst = 1'b0;
    // Pixels in IDLE must not produce anything.
    repeat (40) begin
      pixel_valid = 1'b1;
      pixel_in    = 8'($urandom);
      @(negedge clk);
      n_vec++;
      if (result_valid !== 1'b0 || done_signal !== 1'b0) begin
        n_err++;
        $display("FAIL idle_ignore: got valid=%0b done=%0b expected 0 0", result_valid, done_signal);
      end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic test_vertical_edge();
    run_frame(0, 0, 1'b0);
  endtask

  task automatic test_checkerboard();
    run_frame(1, 0, 1'b0);
  endtask

  task automatic test_ramp_uniform();
    run_frame(2, 0, 1'b0);
    run_frame(3, 0, 1'b0);
  endtask

  task automatic test_gaps();
    run_frame(0, 3, 1'b1);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start_signal = 1'b1;
    @(negedge clk);
    start_signal = 1'b0;
    for (int i = 0; i < 500; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = pix(0, i % W, i / W);
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      pixel_valid = 1'b1;
      pixel_in    = 8'($urandom);
      @(negedge clk);
      n_vec++;
      if (result_valid !== 1'b0 || done_signal !== 1'b0) begin
        n_err++;
        $display("FAIL after_reset_quiet: got valid=%0b done=%0b expected 0 0", result_valid, done_signal);
      end
    end
    pixel_valid = 1'b0;
    run_frame(1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(0, 0, 1'b0);
    run_frame(2, 0, 1'b0);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    start_signal = 1'b0;
    pixel_valid  = 1'b0;
    pixel_in     = 8'd0;
    test_reset();
    test_vertical_edge();
    test_checkerboard();
    test_ramp_uniform();
    test_gaps();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
